// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt-service sequencer.
package pic_pkg;

  localparam int unsigned NUM_IR = 8;
  localparam int unsigned LVL_W  = 3;
  localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    ACK1,
    ACK2,
    DRIVE
  } pic_state_e;

  function automatic logic [NUM_IR-1:0] lvl_onehot(input logic [LVL_W-1:0] lvl);
    return NUM_IR'(1) << lvl;
  endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Fixed-priority (IR0 highest) request resolver with fully nested ISR blocking.
module pic_prio_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] irr,
  input  logic [NUM_IR-1:0] imr,
  input  logic [NUM_IR-1:0] isr,
  output logic              req_valid,
  output logic [LVL_W-1:0]  req_lvl,
  output logic [LVL_W-1:0]  isr_top
);

  logic [NUM_IR-1:0] pending;
  logic              req_found;
  logic              isr_found;

  always_comb begin
    pending   = irr & ~imr;
    req_found = 1'b0;
    req_lvl   = '0;
    isr_found = 1'b0;
    isr_top   = '0;
    for (int unsigned i = 0; i < NUM_IR; i++) begin
      if (pending[i] && !req_found) begin
        req_found = 1'b1;
        req_lvl   = LVL_W'(i);
      end
      if (isr[i] && !isr_found) begin
        isr_found = 1'b1;
        isr_top   = LVL_W'(i);
      end
    end
    // A request must outrank everything already in service.
    req_valid = req_found && (!isr_found || (req_lvl < isr_top));
  end

endmodule

// File: rtl/pic_irq_sequencer.sv
// IRR/ISR ownership, priority resolution and two-pulse INTA vector handshake.
module pic_irq_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IR = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IR-1:0] ir,
  input  logic              inta_n,
  input  logic [4:0]        vec_base,
  input  logic              ltim,
  input  logic              aeoi,
  input  logic [NUM_IR-1:0] imr,
  input  logic              eoi_stb,
  input  logic              eoi_spec,
  input  logic [2:0]        eoi_lvl,
  output logic              int_out,
  output logic [7:0]        vector,
  output logic              drive_en,
  output logic [NUM_IR-1:0] irr,
  output logic [NUM_IR-1:0] isr
);

  pic_state_e        state, state_next;
  logic [NUM_IR-1:0] ir_prev;
  logic              inta_prev;
  logic [2:0]        lvl_q, lvl_next;
  logic              lvl_real_q, lvl_real_next;
  logic [NUM_IR-1:0] irr_next, isr_next;
  logic [7:0]        vector_next;
  logic              int_out_next, drive_en_next;

  logic              inta_fall;
  logic              ack_take;
  logic              ack_vec;
  logic              req_valid;
  logic [2:0]        req_lvl;
  logic [2:0]        isr_top;
  logic [NUM_IR-1:0] ack_set;
  logic [NUM_IR-1:0] aeoi_clr;
  logic [NUM_IR-1:0] eoi_clr;
  logic [NUM_IR-1:0] ir_rise;

  pic_prio_resolver u_prio (
    .irr       (irr),
    .imr       (imr),
    .isr       (isr),
    .req_valid (req_valid),
    .req_lvl   (req_lvl),
    .isr_top   (isr_top)
  );

  assign inta_fall = inta_prev & ~inta_n;
  assign ir_rise   = ir & ~ir_prev;

  always_comb begin
    state_next = state;
    ack_take   = 1'b0;
    ack_vec    = 1'b0;
    case (state)
      IDLE: begin
        if (inta_fall) begin
          state_next = ACK1;
          ack_take   = 1'b1;
        end
      end
      ACK1: begin
        if (inta_fall) begin
          state_next = ACK2;
          ack_vec    = 1'b1;
        end
      end
      ACK2:    state_next = DRIVE;
      DRIVE: begin
        if (inta_n) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    lvl_next      = lvl_q;
    lvl_real_next = lvl_real_q;
    ack_set       = '0;
    aeoi_clr      = '0;
    eoi_clr       = '0;

    if (ack_take) begin
      lvl_next      = req_valid ? req_lvl : SPURIOUS_LVL;
      lvl_real_next = req_valid;
      if (req_valid) ack_set = lvl_onehot(req_lvl);
    end

    // A spurious acknowledge never set an ISR bit, so AEOI has nothing to clear.
    if (ack_vec && aeoi && lvl_real_q) aeoi_clr = lvl_onehot(lvl_q);

    if (eoi_stb) begin
      if (eoi_spec)    eoi_clr = lvl_onehot(eoi_lvl);
      else if (|isr)   eoi_clr = lvl_onehot(isr_top);
    end

    isr_next = (isr & ~eoi_clr & ~aeoi_clr) | ack_set;

    // Edge mode: a bit survives only while its line stays high; ack clear wins.
    if (ltim) irr_next = ir;
    else      irr_next = (irr | ir_rise) & ir & ~ack_set;

    int_out_next  = (state == IDLE) && !inta_fall && req_valid;
    drive_en_next = (state_next == ACK2) || (state_next == DRIVE);
    vector_next   = ack_vec ? {vec_base, lvl_q} : vector;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ir_prev    <= '1;
      inta_prev  <= 1'b1;
      lvl_q      <= '0;
      lvl_real_q <= 1'b0;
      irr        <= '0;
      isr        <= '0;
      int_out    <= 1'b0;
      drive_en   <= 1'b0;
      vector     <= '0;
    end else begin
      state      <= state_next;
      ir_prev    <= ir;
      inta_prev  <= inta_n;
      lvl_q      <= lvl_next;
      lvl_real_q <= lvl_real_next;
      irr        <= irr_next;
      isr        <= isr_next;
      int_out    <= int_out_next;
      drive_en   <= drive_en_next;
      vector     <= vector_next;
    end
  end

endmodule

// File: tb/tb_pic_irq_sequencer.sv
// Directed self-checking bench for pic_irq_sequencer.
module tb_pic_irq_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] ir;
  logic       inta_n;
  logic [4:0] vec_base;
  logic       ltim;
  logic       aeoi;
  logic [7:0] imr;
  logic       eoi_stb;
  logic       eoi_spec;
  logic [2:0] eoi_lvl;
  logic       int_out;
  logic [7:0] vector;
  logic       drive_en;
  logic [7:0] irr;
  logic [7:0] isr;

  int checks   = 0;
  int failures = 0;

  logic [7:0] cap_vec;
  logic       cap_de;

  pic_irq_sequencer #(.NUM_IR(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ir       (ir),
    .inta_n   (inta_n),
    .vec_base (vec_base),
    .ltim     (ltim),
    .aeoi     (aeoi),
    .imr      (imr),
    .eoi_stb  (eoi_stb),
    .eoi_spec (eoi_spec),
    .eoi_lvl  (eoi_lvl),
    .int_out  (int_out),
    .vector   (vector),
    .drive_en (drive_en),
    .irr      (irr),
    .isr      (isr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full two-pulse acknowledge; captures vector/drive_en during the second pulse.
  task automatic do_ack(output logic [7:0] v, output logic de);
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    v  = vector;
    de = drive_en;
    tick();
    inta_n = 1'b1; tick();
  endtask

  task automatic send_eoi(input logic spec, input logic [2:0] lvl);
    eoi_stb = 1'b1; eoi_spec = spec; eoi_lvl = lvl;
    tick();
    eoi_stb = 1'b0; eoi_spec = 1'b0; eoi_lvl = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (int_out !== 1'b0)  begin failures++; $display("FAIL reset_int_out got=%0h exp=0", int_out); end
    checks++; if (vector !== 8'h00)  begin failures++; $display("FAIL reset_vector got=%h exp=00", vector); end
    checks++; if (drive_en !== 1'b0) begin failures++; $display("FAIL reset_drive_en got=%0h exp=0", drive_en); end
    checks++; if (irr !== 8'h00)     begin failures++; $display("FAIL reset_irr got=%h exp=00", irr); end
    checks++; if (isr !== 8'h00)     begin failures++; $display("FAIL reset_isr got=%h exp=00", isr); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_edge_basic();
    ir = 8'h08;
    tick();
    checks++; if (irr !== 8'h08)    begin failures++; $display("FAIL basic_irr_latency got=%h exp=08", irr); end
    checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL basic_int_early got=%0h exp=0", int_out); end
    tick();
    checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL basic_int_out got=%0h exp=1", int_out); end
    inta_n = 1'b0; tick();
    checks++; if (isr !== 8'h08)    begin failures++; $display("FAIL basic_isr_ack1 got=%h exp=08", isr); end
    checks++; if (irr !== 8'h00)    begin failures++; $display("FAIL basic_irr_ack1 got=%h exp=00", irr); end
    checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL basic_int_drop got=%0h exp=0", int_out); end
    tick();
    inta_n = 1'b1; tick();
    checks++; if (drive_en !== 1'b0) begin failures++; $display("FAIL basic_de_between got=%0h exp=0", drive_en); end
    inta_n = 1'b0; tick();
    checks++; if (vector !== 8'h43)  begin failures++; $display("FAIL basic_vector got=%h exp=43", vector); end
    checks++; if (drive_en !== 1'b1) begin failures++; $display("FAIL basic_drive_en got=%0h exp=1", drive_en); end
    tick();
    checks++; if (drive_en !== 1'b1) begin failures++; $display("FAIL basic_drive_hold got=%0h exp=1", drive_en); end
    inta_n = 1'b1; tick();
    checks++; if (drive_en !== 1'b0) begin failures++; $display("FAIL basic_drive_release got=%0h exp=0", drive_en); end
    checks++; if (isr !== 8'h08)     begin failures++; $display("FAIL basic_isr_final got=%h exp=08", isr); end
    checks++; if (irr !== 8'h00)     begin failures++; $display("FAIL basic_irr_final got=%h exp=00", irr); end
    ir = 8'h00;
    send_eoi(1'b0, 3'd0);
    checks++; if (isr !== 8'h00) begin failures++; $display("FAIL basic_eoi_isr got=%h exp=00", isr); end
    tick();
  endtask

  task automatic test_priority();
    ir = 8'h24;
    tick(); tick();
    checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL prio_int_out got=%0h exp=1", int_out); end
    do_ack(cap_vec, cap_de);
    checks++; if (cap_vec !== 8'h42) begin failures++; $display("FAIL prio_vector_ir2 got=%h exp=42", cap_vec); end
    checks++; if (cap_de !== 1'b1)   begin failures++; $display("FAIL prio_drive_en got=%0h exp=1", cap_de); end
    checks++; if (isr !== 8'h04)     begin failures++; $display("FAIL prio_isr got=%h exp=04", isr); end
    checks++; if (irr !== 8'h20)     begin failures++; $display("FAIL prio_irr got=%h exp=20", irr); end
    tick();
    checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL prio_ir5_blocked got=%0h exp=0", int_out); end
    send_eoi(1'b0, 3'd0);
    checks++; if (isr !== 8'h00) begin failures++; $display("FAIL prio_eoi_isr got=%h exp=00", isr); end
    tick();
    checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL prio_ir5_int got=%0h exp=1", int_out); end
    do_ack(cap_vec, cap_de);
    checks++; if (cap_vec !== 8'h45) begin failures++; $display("FAIL prio_vector_ir5 got=%h exp=45", cap_vec); end
    checks++; if (isr !== 8'h20)     begin failures++; $display("FAIL prio_isr_ir5 got=%h exp=20", isr); end
    send_eoi(1'b0, 3'd0);
    ir = 8'h00;
    tick(); tick();
  endtask

  task automatic test_nesting();
    ir = 8'h10;
    tick(); tick();
    do_ack(cap_vec, cap_de);
    checks++; if (cap_vec !== 8'h44) begin failures++; $display("FAIL nest_vector_ir4 got=%h exp=44", cap_vec); end
    ir = 8'h50;
    tick(); tick();
    checks++; if (irr !== 8'h40)    begin failures++; $display("FAIL nest_irr_ir6 got=%h exp=40", irr); end
    checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL nest_ir6_blocked got=%0h exp=0", int_out); end
    ir = 8'h52;
    tick(); tick();
    checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL nest_ir1_int got=%0h exp=1", int_out); end
    do_ack(cap_vec, cap_de);
    checks++; if (cap_vec !== 8'h41) begin failures++; $display("FAIL nest_vector_ir1 got=%h exp=41", cap_vec); end
    checks++; if (isr !== 8'h12)     begin failures++; $display("FAIL nest_isr got=%h exp=12", isr); end
    send_eoi(1'b1, 3'd4);
    checks++; if (isr !== 8'h02) begin failures++; $display("FAIL nest_spec_eoi got=%h exp=02", isr); end
    send_eoi(1'b0, 3'd0);
    checks++; if (isr !== 8'h00) begin failures++; $display("FAIL nest_ns_eoi got=%h exp=00", isr); end
    ir = 8'h00;
    tick(); tick(); tick();
    send_eoi(1'b0, 3'd0);
    checks++; if (isr !== 8'h00) begin failures++; $display("FAIL nest_eoi_empty got=%h exp=00", isr); end
  endtask

  task automatic test_mask();
    imr = 8'h08; ir = 8'h08;
    tick(); tick();
    checks++; if (irr !== 8'h08)    begin failures++; $display("FAIL mask_irr got=%h exp=08", irr); end
    checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL mask_blocked got=%0h exp=0", int_out); end
    imr = 8'h00;
    tick();
    checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL mask_unmask_int got=%0h exp=1", int_out); end
    ir = 8'h00;
    tick(); tick();
    checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL mask_drop_int got=%0h exp=0", int_out); end
  endtask

  task automatic test_aeoi_level();
    ltim = 1'b1; aeoi = 1'b1; ir = 8'h01;
    tick();
    checks++; if (irr !== 8'h01) begin failures++; $display("FAIL aeoi_irr_level got=%h exp=01", irr); end
    tick();
    checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL aeoi_int got=%0h exp=1", int_out); end
    do_ack(cap_vec, cap_de);
    checks++; if (cap_vec !== 8'h40) begin failures++; $display("FAIL aeoi_vector got=%h exp=40", cap_vec); end
    checks++; if (isr !== 8'h00)     begin failures++; $display("FAIL aeoi_isr got=%h exp=00", isr); end
    checks++; if (irr !== 8'h01)     begin failures++; $display("FAIL aeoi_irr_held got=%h exp=01", irr); end
    tick();
    checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL aeoi_reassert got=%0h exp=1", int_out); end
    ir = 8'h00; ltim = 1'b0; aeoi = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_spurious();
    ir = 8'h40;
    tick(); tick();
    checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL spur_int got=%0h exp=1", int_out); end
    ir = 8'h00;
    tick();
    checks++; if (irr !== 8'h00) begin failures++; $display("FAIL spur_irr_drop got=%h exp=00", irr); end
    tick();
    do_ack(cap_vec, cap_de);
    checks++; if (cap_vec !== 8'h47) begin failures++; $display("FAIL spur_vector got=%h exp=47", cap_vec); end
    checks++; if (isr !== 8'h00)     begin failures++; $display("FAIL spur_isr got=%h exp=00", isr); end
    tick();
  endtask

  task automatic test_reset_mid_drive();
    ir = 8'h08;
    tick(); tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    tick();
    checks++; if (drive_en !== 1'b1) begin failures++; $display("FAIL rst_pre_drive got=%0h exp=1", drive_en); end
    rst_n = 1'b0;
    #1;
    checks++; if (drive_en !== 1'b0) begin failures++; $display("FAIL rst_async_drive got=%0h exp=0", drive_en); end
    checks++; if (vector !== 8'h00)  begin failures++; $display("FAIL rst_async_vector got=%h exp=00", vector); end
    checks++; if (isr !== 8'h00)     begin failures++; $display("FAIL rst_async_isr got=%h exp=00", isr); end
    checks++; if (int_out !== 1'b0)  begin failures++; $display("FAIL rst_async_int got=%0h exp=0", int_out); end
    inta_n = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    checks++; if (irr !== 8'h00)    begin failures++; $display("FAIL rst_held_ir_irr got=%h exp=00", irr); end
    checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL rst_held_ir_int got=%0h exp=0", int_out); end
    ir = 8'h00;
    tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    ir       = 8'h00;
    inta_n   = 1'b1;
    vec_base = 5'b01000;
    ltim     = 1'b0;
    aeoi     = 1'b0;
    imr      = 8'h00;
    eoi_stb  = 1'b0;
    eoi_spec = 1'b0;
    eoi_lvl  = 3'd0;

    test_reset();
    test_edge_basic();
    test_priority();
    test_nesting();
    test_mask();
    test_aeoi_level();
    test_spurious();
    test_reset_mid_drive();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
